// File: rtl/morse_pkg.sv
// morse_pkg: shared states, scan-code constants, unit multipliers and the
// PS/2 set-2 make code to Morse pattern lookup for morse_tx_sequencer.
package morse_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ELEM_ON, ELEM_GAP, CHAR_GAP, WORD_GAP} state_t;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [2:0] DIT  = 3'd1;
  localparam logic [2:0] DAH  = 3'd3;
  localparam logic [2:0] EGAP = 3'd1;
  localparam logic [2:0] CGAP = 3'd3;
  localparam logic [2:0] WGAP = 3'd4;

  // Returns {valid, len[2:0], pattern[4:0]}; pattern is left-aligned so bit 4 is the first element, 1=dah.
  function automatic logic [8:0] morse_lookup(input logic [7:0] code);
    logic [8:0] r;
    case (code)
      8'h1C: r = {1'b1, 3'd2, 5'b01000};
      8'h32: r = {1'b1, 3'd4, 5'b10000};
      8'h21: r = {1'b1, 3'd4, 5'b10100};
      8'h23: r = {1'b1, 3'd3, 5'b10000};
      8'h24: r = {1'b1, 3'd1, 5'b00000};
      8'h2B: r = {1'b1, 3'd4, 5'b00100};
      8'h34: r = {1'b1, 3'd3, 5'b11000};
      8'h33: r = {1'b1, 3'd4, 5'b00000};
      8'h43: r = {1'b1, 3'd2, 5'b00000};
      8'h3B: r = {1'b1, 3'd4, 5'b01110};
      8'h42: r = {1'b1, 3'd3, 5'b10100};
      8'h4B: r = {1'b1, 3'd4, 5'b01000};
      8'h3A: r = {1'b1, 3'd2, 5'b11000};
      8'h31: r = {1'b1, 3'd2, 5'b10000};
      8'h44: r = {1'b1, 3'd3, 5'b11100};
      8'h4D: r = {1'b1, 3'd4, 5'b01100};
      8'h15: r = {1'b1, 3'd4, 5'b11010};
      8'h2D: r = {1'b1, 3'd3, 5'b01000};
      8'h1B: r = {1'b1, 3'd3, 5'b00000};
      8'h2C: r = {1'b1, 3'd1, 5'b10000};
      8'h3C: r = {1'b1, 3'd3, 5'b00100};
      8'h2A: r = {1'b1, 3'd4, 5'b00010};
      8'h1D: r = {1'b1, 3'd3, 5'b01100};
      8'h22: r = {1'b1, 3'd4, 5'b10010};
      8'h35: r = {1'b1, 3'd4, 5'b10110};
      8'h1A: r = {1'b1, 3'd4, 5'b11000};
      8'h45: r = {1'b1, 3'd5, 5'b11111};
      8'h16: r = {1'b1, 3'd5, 5'b01111};
      8'h1E: r = {1'b1, 3'd5, 5'b00111};
      8'h26: r = {1'b1, 3'd5, 5'b00011};
      8'h25: r = {1'b1, 3'd5, 5'b00001};
      8'h2E: r = {1'b1, 3'd5, 5'b00000};
      8'h36: r = {1'b1, 3'd5, 5'b10000};
      8'h3D: r = {1'b1, 3'd5, 5'b11000};
      8'h3E: r = {1'b1, 3'd5, 5'b11100};
      8'h46: r = {1'b1, 3'd5, 5'b11110};
      SC_BREAK, SC_EXT: r = '0;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// morse_unit_timer: loadable down-counter lasting units*unit_len cycles;
// done is high on the last cycle of the loaded duration.
module morse_unit_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [2:0]       units,
  input  logic [CNT_W-1:0] unit_len,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [CNT_W-1:0] total;

  assign total = CNT_W'(units) * unit_len;
  assign done  = run && cnt == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= total - CNT_W'(1);
      run <= 1'b1;
    end else if (run) begin
      cnt <= (cnt == '0) ? cnt : cnt - CNT_W'(1);
      run <= cnt != '0;
    end
  end

endmodule

// File: rtl/morse_tx_sequencer.sv
// morse_tx_sequencer: pops PS/2 make codes and keys them out as Morse with unit timing.
// Optional MORSE_SPEED_SEL_EN adds speed_sel[1:0] to shorten the unit per character.
module morse_tx_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_data,
  input  logic       code_valid,
`ifdef MORSE_SPEED_SEL_EN
  input  logic [1:0] speed_sel,
`endif
  output logic       code_ready,
  output logic       morse_out,
  output logic       dit_out,
  output logic       dah_out,
  output logic       busy
);

  localparam int CNT_W = $clog2(4 * UNIT_CYCLES);

  state_t           state, next;
  logic [7:0]       code_q;
  logic [4:0]       pat_q;
  logic [2:0]       left_q;
  logic             lut_valid;
  logic [2:0]       lut_len;
  logic [4:0]       lut_pat;
  logic             accept, load, done, elem;
  logic [2:0]       units;
  logic [CNT_W-1:0] unit_len;

  assign accept = code_valid && code_ready;
  assign {lut_valid, lut_len, lut_pat} = morse_lookup(code_q);
  assign elem = (state == LOAD) ? lut_pat[4] : pat_q[4];

`ifdef MORSE_SPEED_SEL_EN
  logic [31:0] shifted;
  assign shifted = 32'(UNIT_CYCLES) >> speed_sel;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) unit_len <= CNT_W'(UNIT_CYCLES);
    else if (accept) unit_len <= CNT_W'((shifted < 32'd2) ? 32'd2 : shifted);
  end
`else
  assign unit_len = CNT_W'(UNIT_CYCLES);
`endif

  morse_unit_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .units   (units),
    .unit_len(unit_len),
    .done    (done)
  );

  always_comb begin
    next  = state;
    load  = 1'b0;
    units = DIT;
    case (state)
      IDLE: next = accept ? LOAD : IDLE;
      LOAD: begin
        next  = lut_valid ? ELEM_ON : (code_q == SC_SPACE) ? WORD_GAP : IDLE;
        load  = lut_valid || code_q == SC_SPACE;
        units = lut_valid ? (elem ? DAH : DIT) : WGAP;
      end
      ELEM_ON: begin
        next  = !done ? ELEM_ON : (left_q > 3'd1) ? ELEM_GAP : CHAR_GAP;
        load  = done;
        units = (left_q > 3'd1) ? EGAP : CGAP;
      end
      ELEM_GAP: begin
        next  = done ? ELEM_ON : ELEM_GAP;
        load  = done;
        units = elem ? DAH : DIT;
      end
      CHAR_GAP, WORD_GAP: next = done ? IDLE : state;
      default: next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code_q     <= '0;
      pat_q      <= '0;
      left_q     <= '0;
      code_ready <= 1'b0;
      busy       <= 1'b0;
      morse_out  <= 1'b0;
      dit_out    <= 1'b0;
      dah_out    <= 1'b0;
    end else begin
      state      <= next;
      code_ready <= next == IDLE;
      busy       <= next != IDLE;
      morse_out  <= next == ELEM_ON;
      dit_out    <= next == ELEM_ON && !elem;
      dah_out    <= next == ELEM_ON && elem;
      if (accept) code_q <= code_data;
      if (state == LOAD) begin
        pat_q  <= lut_pat;
        left_q <= lut_len;
      end else if (state == ELEM_ON && done) begin
        pat_q  <= pat_q << 1;
        left_q <= left_q - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// tb_morse_tx_sequencer: randomized self-checking bench; expected waveforms are
// built from dot/dash strings and Morse unit timing rules.
module tb_morse_tx_sequencer;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code_data = '0;
  logic       code_valid = 1'b0;
  logic       code_ready, morse_out, dit_out, dah_out, busy;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  morse_tx_sequencer #(.UNIT_CYCLES(U)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_data (code_data),
    .code_valid(code_valid),
`ifdef MORSE_SPEED_SEL_EN
    .speed_sel (2'b00),
`endif
    .code_ready(code_ready),
    .morse_out (morse_out),
    .dit_out   (dit_out),
    .dah_out   (dah_out),
    .busy      (busy)
  );

  logic [7:0] codes [36] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
    8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
    8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string pats [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---", "-.-", ".-..",
    "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--..", "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."};

  // Expected word is {busy, code_ready, morse_out, dit_out, dah_out}.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {busy, code_ready, morse_out, dit_out, dah_out};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  function automatic string pat_of(input logic [7:0] c);
    for (int i = 0; i < 36; i++) if (codes[i] == c) return pats[i];
    return "";
  endfunction

  // Entered at a negedge with the sequencer idle; drives the code and checks every cycle until idle again.
  task automatic send(input logic [7:0] c, input string tag);
    logic [4:0] q[$];
    string      s;
    s = pat_of(c);
    q.push_back(5'b10000);
    for (int k = 0; k < s.len(); k++) begin
      repeat ((s[k] == "-" ? 3 : 1) * U) q.push_back(s[k] == "-" ? 5'b10101 : 5'b10110);
      if (k < s.len() - 1) repeat (U) q.push_back(5'b10000);
    end
    if (s.len() > 0) repeat (3 * U) q.push_back(5'b10000);
    else if (c == 8'h29) repeat (4 * U) q.push_back(5'b10000);
    q.push_back(5'b01000);
    code_data  = c;
    code_valid = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      chk(tag, q[i]);
      if (i < q.size() - 1) begin
        code_valid = 1'($urandom);
        code_data  = 8'($urandom);
      end else code_valid = 1'b0;
    end
  endtask

  initial begin
    int order [36];
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", 5'b00000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 5'b01000);
    send(8'h24, "E");
    send(8'h1C, "A");
    send(8'h45, "digit0");
    send(8'h29, "space");
    send(8'h76, "unknown76");
    send(8'hF0, "break");
    send(8'hE0, "ext");
    code_data  = 8'h2C;
    code_valid = 1'b1;
    @(negedge clk);
    chk("T_load", 5'b10000);
    code_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("T_mid_dah", 5'b10101);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 5'b00000);
    @(negedge clk);
    chk("reset_mid_hold", 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 5'b01000);
    send(8'h24, "E_after_reset");
    for (int i = 0; i < 36; i++) order[i] = i;
    for (int i = 35; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 36; i++) begin
      repeat ($urandom_range(2, 0)) begin
        @(negedge clk);
        chk("idle", 5'b01000);
      end
      send(codes[order[i]], "rand_char");
      if ($urandom_range(3, 0) == 0) send(8'h29, "rand_space");
      if ($urandom_range(5, 0) == 0) send(8'($urandom), "rand_any");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_tx_sequencer.md
Name: morse_tx_sequencer

Overview:
Sequences Morse keying from a stream of PS/2 set-2 make codes buffered upstream of the Morse output stage. Pops one code at a time over a valid/ready handshake and looks up its Morse pattern. Drives the key and dit/dah indicator outputs with standard unit timing: dit 1, dah 3, element gap 1, character gap 3, word gap 7. Sits between the code buffer and the output pins.

Parameters:
UNIT_CYCLES, 1000000, clock cycles per Morse time unit (100 ms at 10 MHz); minimum 2
CNT_W, $clog2(4*UNIT_CYCLES), width of the duration counter (localparam, derived)

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
code_data  in  8  PS/2 set-2 make code
code_valid  in  1  code_data valid
code_ready  out  1  sequencer accepts a code; transfer occurs when code_valid && code_ready on a rising clk edge
morse_out  out  1  key output; equals dit_out | dah_out, registered
dit_out  out  1  high for the duration of a dit element
dah_out  out  1  high for the duration of a dah element
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, counter 0. morse_out, dit_out, dah_out, busy and code_ready are all 0. Takes effect immediately mid-element; the remaining pattern is discarded.
- code_ready = 1 only in IDLE while out of reset, so the sequencer accepts at most one code at a time.
- States: IDLE, LOAD, ELEM_ON, ELEM_GAP, CHAR_GAP, WORD_GAP.
- IDLE: on accept, register code_data -> LOAD.
- LOAD (1 cycle): registered table lookup gives len (0..5) and pattern[4:0]; pattern is MSB-first, 1=dah.
  - Letters A-Z and digits 0-9 -> ELEM_ON with the first element.
  - Space (0x29) -> WORD_GAP.
  - Any other code, including 0xF0 break and 0xE0 extended prefix -> IDLE, with no output.
- ELEM_ON: dit = 1 unit, dah = 3 units. Only the matching indicator is high; morse_out is high.
  - When the duration expires: more elements remain -> ELEM_GAP; otherwise -> CHAR_GAP.
- ELEM_GAP: 1 unit, all outputs low -> ELEM_ON with the next element.
- CHAR_GAP: 3 units -> IDLE.
- WORD_GAP: 4 units -> IDLE. Together with the preceding character's CHAR_GAP this gives a 7-unit word gap.
- Duration counter: loaded with n*UNIT_CYCLES-1 on state entry, decrements each cycle, transitions at 0. A state lasting n units lasts exactly n*UNIT_CYCLES cycles.
- Latency: code accepted at edge T -> LOAD during T+1 -> first element outputs high from T+2.
- code_valid dropping while not in IDLE has no effect.
- code_data is sampled only at acceptance.

Optional Feature:
MORSE_SPEED_SEL_EN
- Defined: adds input speed_sel[1:0], sampled at acceptance. The unit for that character becomes UNIT_CYCLES >> speed_sel, so 0=1x, 1=2x, 2=4x, 3=8x faster. The effective unit is clamped to a minimum of 2 cycles.
- Undefined: no port is added and the unit is fixed at UNIT_CYCLES.

Decomposition:
- Package morse_pkg contains:
  - state enum
  - scan-code constants (SC_SPACE=0x29, SC_BREAK=0xF0, SC_EXT=0xE0)
  - unit multipliers (DIT=1, DAH=3, EGAP=1, CGAP=3, WGAP=4)
  - lookup function: scan code -> {valid, len[2:0], pattern[4:0]}
- One sub-module, morse_unit_timer: loadable down-counter taking a unit count and a unit length, with a done pulse. The FSM stays in the top of the block.

Test Plan (UNIT_CYCLES=4):
- Reset, then release -> all outputs 0 while rst_n=0; code_ready=1 on the first cycle after release.
- 'E' (0x24) accepted at T -> dit_out/morse_out high T+2..T+5; CHAR_GAP T+6..T+17; code_ready=1 at T+18.
- 'A' (0x1C) -> dit high T+2..T+5; gap T+6..T+9; dah high T+10..T+21; code_ready=1 at T+34.
- '0' (0x45) followed by space (0x29) -> five 12-cycle dahs separated by 4-cycle gaps; then 12 + 16 = 28 low cycles before the next accept.
- Unknown code 0x76 -> no output pulse; code_ready=1 two cycles after acceptance.
- rst_n asserted mid-dah of 'T' (0x2C) -> outputs 0 asynchronously; after release the sequencer is IDLE and accepts the next code without any residual pulse.
